// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// master = control unit, slave = datapath.
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       PCEn;
    logic       IorD;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ZeroExt;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    logic       InstrDone;
    logic       Halted;

    modport master (
        input  Opcode, Zero,
        output PCEn, IorD, IRWrite, MemWrite, RegWrite, RegDst,
        output MemtoReg, ALUSrcA, ALUSrcB, ZeroExt, PCSrc, ALUOp,
        output InstrDone, Halted
    );

    modport slave (
        output Opcode, Zero,
        input  PCEn, IorD, IRWrite, MemWrite, RegWrite, RegDst,
        input  MemtoReg, ALUSrcA, ALUSrcB, ZeroExt, PCSrc, ALUOp,
        input  InstrDone, Halted
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// Only PCEn depends combinationally on an input (Zero).
module multicycle_control #(
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input logic clk,
    input logic reset,
    multicycle_control_if.master bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC_R  = 4'd6,
        S_ALUWB   = 4'd7,
        S_ADDI_EX = 4'd8,
        S_ORI_EX  = 4'd9,
        S_IMMWB   = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12,
        S_HALT    = 4'd13
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       bne_q;

    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       halted;

    // State register and branch-sense flag captured while decoding
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            bne_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                bne_q <= (bus.Opcode == OP_BNE);
            end
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        state_next = S_FETCH;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        zero_ext   = 1'b0;
        pc_src     = 2'b00;
        alu_op     = 3'b000;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b01;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (bus.Opcode)
                    OP_LW, OP_SW:   state_next = S_MEMADR;
                    OP_R:           state_next = S_EXEC_R;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_ADDI:        state_next = S_ADDI_EX;
                    OP_ORI:         state_next = S_ORI_EX;
                    OP_J:           state_next = S_JUMP;
                    default: begin
                        state_next = TRAP_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b111;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = 3'b100;
                state_next = S_IMMWB;
            end
            S_ORI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = 3'b101;
                zero_ext   = 1'b1;
                state_next = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b001;
                pc_src     = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
            end
            S_HALT: begin
                halted     = 1'b1;
                state_next = S_HALT;
            end
            default: state_next = S_FETCH;
        endcase
    end

    assign bus.PCEn      = pc_write | (branch & (bus.Zero ^ bne_q));
    assign bus.IorD      = iord;
    assign bus.IRWrite   = ir_write;
    assign bus.MemWrite  = mem_write;
    assign bus.RegWrite  = reg_write;
    assign bus.RegDst    = reg_dst;
    assign bus.MemtoReg  = mem_to_reg;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ZeroExt   = zero_ext;
    assign bus.PCSrc     = pc_src;
    assign bus.ALUOp     = alu_op;
    assign bus.InstrDone = instr_done;
    assign bus.Halted    = halted;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (trap on / trap off)
// checked every cycle against an instruction/cycle-count model.
module tb_multicycle_control;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       done;
        logic       halted;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = OP_LW;
    logic       zero = 1'b0;

    int checks = 0;
    int failures = 0;

    multicycle_control_if bus0 ();
    multicycle_control_if bus1 ();

    assign bus0.Opcode = opcode;
    assign bus0.Zero   = zero;
    assign bus1.Opcode = opcode;
    assign bus1.Zero   = zero;

    multicycle_control #(.TRAP_ILLEGAL(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    multicycle_control #(.TRAP_ILLEGAL(1'b0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    always #5 clk = ~clk;

    outs_t act [2];
    assign act[0] = {bus0.PCEn, bus0.IorD, bus0.IRWrite, bus0.MemWrite,
                     bus0.RegWrite, bus0.RegDst, bus0.MemtoReg,
                     bus0.ALUSrcA, bus0.ALUSrcB, bus0.ZeroExt,
                     bus0.PCSrc, bus0.ALUOp, bus0.InstrDone, bus0.Halted};
    assign act[1] = {bus1.PCEn, bus1.IorD, bus1.IRWrite, bus1.MemWrite,
                     bus1.RegWrite, bus1.RegDst, bus1.MemtoReg,
                     bus1.ALUSrcA, bus1.ALUSrcB, bus1.ZeroExt,
                     bus1.PCSrc, bus1.ALUOp, bus1.InstrDone, bus1.Halted};

    // Model: cycle number k within the current instruction (1 = FETCH)
    bit         m_valid = 1'b0;
    int         m_k [2];
    bit         m_halt [2];
    logic [5:0] m_op [2];

    function automatic bit known_op(logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_BNE || op == OP_ADDI ||
               op == OP_ORI || op == OP_J;
    endfunction

    function automatic int instr_len(logic [5:0] op);
        if (op == OP_LW) return 5;
        if (op == OP_BEQ || op == OP_BNE || op == OP_J) return 3;
        return 4;
    endfunction

    function automatic outs_t expect_out(logic [5:0] op, int k,
                                         bit hlt, logic z);
        outs_t e = '0;
        if (hlt) begin
            e.halted = 1'b1;
            return e;
        end
        if (k == 1) begin
            e.irwrite = 1'b1;
            e.pcen    = 1'b1;
            e.alusrcb = 2'b01;
        end else if (k == 2) begin
            e.alusrcb = 2'b11;
        end else if (op == OP_LW || op == OP_SW) begin
            if (k == 3) begin
                e.alusrca = 1'b1;
                e.alusrcb = 2'b10;
            end else if (op == OP_LW && k == 4) begin
                e.iord = 1'b1;
            end else if (op == OP_LW) begin
                e.memtoreg = 1'b1;
                e.regwrite = 1'b1;
                e.done     = 1'b1;
            end else begin
                e.iord     = 1'b1;
                e.memwrite = 1'b1;
                e.done     = 1'b1;
            end
        end else if (op == OP_R) begin
            if (k == 3) begin
                e.alusrca = 1'b1;
                e.aluop   = 3'd7;
            end else begin
                e.regdst   = 1'b1;
                e.regwrite = 1'b1;
                e.done     = 1'b1;
            end
        end else if (op == OP_ADDI || op == OP_ORI) begin
            if (k == 3) begin
                e.alusrca = 1'b1;
                e.alusrcb = 2'b10;
                e.aluop   = (op == OP_ORI) ? 3'd5 : 3'd4;
                e.zeroext = (op == OP_ORI);
            end else begin
                e.regwrite = 1'b1;
                e.done     = 1'b1;
            end
        end else if (op == OP_BEQ || op == OP_BNE) begin
            e.alusrca = 1'b1;
            e.aluop   = 3'd1;
            e.pcsrc   = 2'b01;
            e.done    = 1'b1;
            e.pcen    = z ^ (op == OP_BNE);
        end else begin
            e.pcen  = 1'b1;
            e.pcsrc = 2'b10;
            e.done  = 1'b1;
        end
        return e;
    endfunction

    // Advance the model on each rising edge from the sampled inputs
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_k[i]    = 1;
                m_halt[i] = 1'b0;
            end else if (!m_halt[i]) begin
                if (m_k[i] == 1) begin
                    m_k[i] = 2;
                end else if (m_k[i] == 2) begin
                    m_op[i] = opcode;
                    if (known_op(opcode)) m_k[i] = 3;
                    else if (i == 0) m_halt[i] = 1'b1;
                    else m_k[i] = 1;
                end else if (m_k[i] >= instr_len(m_op[i])) begin
                    m_k[i] = 1;
                end else begin
                    m_k[i] = m_k[i] + 1;
                end
            end
        end
        if (reset) m_valid = 1'b1;
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                outs_t e;
                e = expect_out(m_op[i], m_k[i], m_halt[i], zero);
                checks++;
                if (act[i] !== e) begin
                    failures++;
                    $display("FAIL model_dut%0d t=%0t got=%h want=%h",
                             i, $time, act[i], e);
                end
                checks++;
                if ((act[i].memwrite & act[i].regwrite) !== 1'b0) begin
                    failures++;
                    $display("FAIL memwr_regwr_dut%0d t=%0t got=1 want=0",
                             i, $time);
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    initial begin
        reset  = 1'b1;
        opcode = OP_LW;
        zero   = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("rst_irwrite", 32'(bus0.IRWrite), 1);
        chk("rst_pcen", 32'(bus0.PCEn), 1);
        chk("rst_alusrcb", 32'(bus0.ALUSrcB), 1);
        chk("rst_done", 32'(bus0.InstrDone), 0);
        chk("rst_halted", 32'(bus0.Halted), 0);
        cyc(1);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_irwrite", 32'(bus0.IRWrite), 1);
        // LW: cycle 5 is the write-back
        cyc(4);
        @(negedge clk);
        chk("lw_memtoreg", 32'(bus0.MemtoReg), 1);
        chk("lw_regwrite", 32'(bus0.RegWrite), 1);
        chk("lw_done", 32'(bus0.InstrDone), 1);
        cyc(1);
        opcode = OP_R;
        cyc(2);
        @(negedge clk);
        chk("r_aluop", 32'(bus0.ALUOp), 7);
        cyc(1);
        @(negedge clk);
        chk("r_regdst", 32'(bus0.RegDst), 1);
        chk("r_regwrite", 32'(bus0.RegWrite), 1);
        cyc(1);
        @(negedge clk);
        chk("r_back_fetch", 32'(bus0.IRWrite), 1);
        // Branches: taken/not-taken for both senses
        opcode = OP_BEQ;
        zero   = 1'b1;
        cyc(2);
        @(negedge clk);
        chk("beq_z1_pcen", 32'(bus0.PCEn), 1);
        cyc(1);
        zero = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("beq_z0_pcen", 32'(bus0.PCEn), 0);
        cyc(1);
        opcode = OP_BNE;
        cyc(2);
        @(negedge clk);
        chk("bne_z0_pcen", 32'(bus0.PCEn), 1);
        cyc(1);
        zero = 1'b1;
        cyc(2);
        @(negedge clk);
        chk("bne_z1_pcen", 32'(bus0.PCEn), 0);
        cyc(1);
        opcode = OP_ORI;
        cyc(2);
        @(negedge clk);
        chk("ori_aluop", 32'(bus0.ALUOp), 5);
        chk("ori_zeroext", 32'(bus0.ZeroExt), 1);
        cyc(2);
        opcode = OP_ADDI;
        cyc(2);
        @(negedge clk);
        chk("addi_aluop", 32'(bus0.ALUOp), 4);
        chk("addi_zeroext", 32'(bus0.ZeroExt), 0);
        cyc(2);
        opcode = OP_J;
        cyc(2);
        @(negedge clk);
        chk("j_pcen", 32'(bus0.PCEn), 1);
        chk("j_pcsrc", 32'(bus0.PCSrc), 2);
        cyc(1);
        // Reset in the middle of a store
        opcode = OP_SW;
        cyc(3);
        @(negedge clk);
        chk("sw_memwrite", 32'(bus0.MemWrite), 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        @(negedge clk);
        chk("sw_rst_memwrite", 32'(bus0.MemWrite), 0);
        chk("sw_rst_fetch", 32'(bus0.IRWrite), 1);
        // Illegal opcode: trap vs. refetch
        opcode = OP_BAD;
        cyc(2);
        @(negedge clk);
        chk("bad_trap_halted", 32'(bus0.Halted), 1);
        chk("bad_notrap_fetch", 32'(bus1.IRWrite), 1);
        chk("bad_notrap_halted", 32'(bus1.Halted), 0);
        cyc(3);
        @(negedge clk);
        chk("bad_trap_held", 32'(bus0.Halted), 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        @(negedge clk);
        chk("halt_rst_halted", 32'(bus0.Halted), 0);
        chk("halt_rst_irwrite", 32'(bus0.IRWrite), 1);
        chk("halt_rst_pcen", 32'(bus0.PCEn), 1);
        opcode = OP_LW;
        cyc(10);
        opcode = OP_BNE;
        zero   = 1'b0;
        cyc(6);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
